// File: rtl/wb_stage.sv
// Write-back stage of the DLX pipeline.
// Selects the ALU result or the returned load data and commits it to the register-file write
// port. A load waits for the data-memory handshake, and a big-endian sub-word is extracted and
// sign- or zero-extended. The pipeline is stalled while a load is outstanding, and the load is
// abandoned after MAX_WAIT cycles.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   d_data_valid        data memory read data valid this cycle
//   d_data_read         data memory read data
//   d_load_enable_WB    instruction in WB is a load
//   load_size_WB        00 byte, 01 halfword, 10/11 word
//   load_signed_WB      sign-extend (1) or zero-extend (0) sub-word loads
//   addr_lo_WB          low two bits of the load address
//   ALU_out_WB          ALU result for non-load instructions
//   reg_write_WB        instruction writes Rd
//   Rd_WB               destination register
//   stall_WB            hold PC and upstream pipeline registers
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   ALU_out_WB_backward, Rd_WB_backward  WB->EX forwarding path
//   err_misaligned, err_timeout          sticky error flags
module wb_stage #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        d_data_valid,
    input  logic [31:0] d_data_read,
    input  logic        d_load_enable_WB,
    input  logic [1:0]  load_size_WB,
    input  logic        load_signed_WB,
    input  logic [1:0]  addr_lo_WB,
    input  logic [31:0] ALU_out_WB,
    input  logic        reg_write_WB,
    input  logic [4:0]  Rd_WB,
    output logic        stall_WB,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] ALU_out_WB_backward,
    output logic [4:0]  Rd_WB_backward,
    output logic        err_misaligned,
    output logic        err_timeout
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        misaligned;
    logic        timeout_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    logic        stall;
    logic        commit;
    logic [31:0] commit_data;
    logic        set_mis;
    logic        set_to;

    assign misaligned = d_load_enable_WB &&
                        ((load_size_WB == 2'b01 && addr_lo_WB[0]) ||
                         (load_size_WB[1] && addr_lo_WB != 2'b00));

    assign timeout_hit = (state_q == StWait) && !d_data_valid &&
                         (cnt_q == CNT_W'(MAX_WAIT));

    // Big-endian sub-word extraction.
    always_comb begin
        byte_sel = d_data_read[31:24];
        unique case (addr_lo_WB)
            2'b00: byte_sel = d_data_read[31:24];
            2'b01: byte_sel = d_data_read[23:16];
            2'b10: byte_sel = d_data_read[15:8];
            2'b11: byte_sel = d_data_read[7:0];
            default: byte_sel = d_data_read[31:24];
        endcase
        half_sel = addr_lo_WB[1] ? d_data_read[15:0] : d_data_read[31:16];
        case (load_size_WB)
            2'b00:   load_data = {{24{load_signed_WB & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{load_signed_WB & half_sel[15]}}, half_sel};
            default: load_data = d_data_read;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (d_load_enable_WB && !misaligned && !d_data_valid) begin
                    state_d = StWait;
                    cnt_d   = CNT_W'(1);
                end
            end
            StWait: begin
                if (d_data_valid || timeout_hit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        stall       = 1'b0;
        commit      = 1'b0;
        commit_data = load_data;
        set_mis     = 1'b0;
        set_to      = 1'b0;
        case (state_q)
            StIdle: begin
                if (d_load_enable_WB) begin
                    if (misaligned) begin
                        set_mis = 1'b1;
                    end else if (d_data_valid) begin
                        commit = reg_write_WB;
                    end else begin
                        stall = 1'b1;
                    end
                end else begin
                    commit      = reg_write_WB;
                    commit_data = ALU_out_WB;
                end
            end
            StWait: begin
                if (d_data_valid) begin
                    commit = reg_write_WB;
                end else if (timeout_hit) begin
                    set_to = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: ;
        endcase
        // Writes to r0 are dropped entirely.
        if (Rd_WB == 5'd0) begin
            commit = 1'b0;
        end
    end

    // Gated so that stall reads low throughout reset, even with a load presented.
    assign stall_WB = stall & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            rf_we <= commit;
            if (commit) begin
                rf_waddr <= Rd_WB;
                rf_wdata <= commit_data;
            end
            if (set_mis) err_misaligned <= 1'b1;
            if (set_to)  err_timeout    <= 1'b1;
        end
    end

    assign ALU_out_WB_backward = rf_wdata;
    assign Rd_WB_backward      = rf_we ? rf_waddr : 5'd0;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        d_data_valid;
    logic [31:0] d_data_read;
    logic        d_load_enable_WB;
    logic [1:0]  load_size_WB;
    logic        load_signed_WB;
    logic [1:0]  addr_lo_WB;
    logic [31:0] ALU_out_WB;
    logic        reg_write_WB;
    logic [4:0]  Rd_WB;
    logic        stall_WB;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] ALU_out_WB_backward;
    logic [4:0]  Rd_WB_backward;
    logic        err_misaligned;
    logic        err_timeout;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_stage #(.MAX_WAIT(4), .CNT_W(5)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .d_data_valid        (d_data_valid),
        .d_data_read         (d_data_read),
        .d_load_enable_WB    (d_load_enable_WB),
        .load_size_WB        (load_size_WB),
        .load_signed_WB      (load_signed_WB),
        .addr_lo_WB          (addr_lo_WB),
        .ALU_out_WB          (ALU_out_WB),
        .reg_write_WB        (reg_write_WB),
        .Rd_WB               (Rd_WB),
        .stall_WB            (stall_WB),
        .rf_we               (rf_we),
        .rf_waddr            (rf_waddr),
        .rf_wdata            (rf_wdata),
        .ALU_out_WB_backward (ALU_out_WB_backward),
        .Rd_WB_backward      (Rd_WB_backward),
        .err_misaligned      (err_misaligned),
        .err_timeout         (err_timeout)
    );

    typedef struct {
        logic        ld;
        logic [1:0]  sz;
        logic        sgn;
        logic [1:0]  al;
        logic [31:0] alu;
        logic        rw;
        logic [4:0]  rd;
        logic        vld;
        logic [31:0] dat;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic        e_mis;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [1:0] sz, input logic sgn,
                         input logic [1:0] al, input logic [31:0] alu, input logic rw,
                         input logic [4:0] rd, input logic vld, input logic [31:0] dat);
        d_load_enable_WB = ld;
        load_size_WB     = sz;
        load_signed_WB   = sgn;
        addr_lo_WB       = al;
        ALU_out_WB       = alu;
        reg_write_WB     = rw;
        Rd_WB            = rd;
        d_data_valid     = vld;
        d_data_read      = dat;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d);
        chk({tag, " rf_we"}, 32'(rf_we), 32'(we));
        chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(a));
        chk({tag, " rf_wdata"}, rf_wdata, d);
        chk({tag, " fwd_data"}, ALU_out_WB_backward, d);
        chk({tag, " fwd_rd"}, 32'(Rd_WB_backward), we ? 32'(a) : 32'd0);
    endtask

    initial begin
        //          ld   sz     sgn   al     alu            rw    rd      vld   dat
        //          e_we e_a    e_d            e_mis
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_1234, 1'b1, 5'd5,  1'b0, 32'h0,
                     1'b1, 5'd5,  32'h0000_1234, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 1'b1, 2'd1, 32'h0,         1'b1, 5'd7,  1'b1, 32'h1280_3456,
                     1'b1, 5'd7,  32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 2'd1, 32'h0,         1'b1, 5'd8,  1'b1, 32'h1280_3456,
                     1'b1, 5'd8,  32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b1, 2'd1, 1'b1, 2'd0, 32'h0,         1'b1, 5'd9,  1'b1, 32'h8001_ABCD,
                     1'b1, 5'd9,  32'hFFFF_8001, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 2'd2, 32'h0,         1'b1, 5'd10, 1'b1, 32'h1234_F00D,
                     1'b1, 5'd10, 32'h0000_F00D, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 1'b1, 2'd0, 32'h0,         1'b1, 5'd11, 1'b1, 32'hDEAD_BEEF,
                     1'b1, 5'd11, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b1, 2'd3, 1'b1, 2'd0, 32'h0,         1'b1, 5'd12, 1'b1, 32'hCAFE_F00D,
                     1'b1, 5'd12, 32'hCAFE_F00D, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 1'b1, 2'd3, 32'h0,         1'b1, 5'd13, 1'b1, 32'h0000_007F,
                     1'b1, 5'd13, 32'h0000_007F, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 1'b1, 2'd0, 32'h0,         1'b1, 5'd14, 1'b1, 32'h9A00_0000,
                     1'b1, 5'd14, 32'hFFFF_FF9A, 1'b0};
        vecs[9]  = '{1'b1, 2'd0, 1'b0, 2'd2, 32'h0,         1'b1, 5'd15, 1'b1, 32'h0000_C300,
                     1'b1, 5'd15, 32'h0000_00C3, 1'b0};
        // Load to r0, non-load without write, non-load to r0: no write, port holds.
        vecs[10] = '{1'b1, 2'd2, 1'b0, 2'd0, 32'h0,         1'b1, 5'd0,  1'b1, 32'h1111_1111,
                     1'b0, 5'd15, 32'h0000_00C3, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_5555, 1'b0, 5'd3,  1'b0, 32'h0,
                     1'b0, 5'd15, 32'h0000_00C3, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_6666, 1'b1, 5'd0,  1'b0, 32'h0,
                     1'b0, 5'd15, 32'h0000_00C3, 1'b0};
        // Stray valid on a non-load is ignored.
        vecs[13] = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_A5A5, 1'b1, 5'd20, 1'b1, 32'hFFFF_FFFF,
                     1'b1, 5'd20, 32'h0000_A5A5, 1'b0};
        // Misaligned word, then misaligned halfword, then a normal op: flag stays set.
        vecs[14] = '{1'b1, 2'd2, 1'b0, 2'd2, 32'h0,         1'b1, 5'd21, 1'b1, 32'h2222_2222,
                     1'b0, 5'd20, 32'h0000_A5A5, 1'b1};
        vecs[15] = '{1'b1, 2'd1, 1'b0, 2'd1, 32'h0,         1'b1, 5'd21, 1'b1, 32'h3333_3333,
                     1'b0, 5'd20, 32'h0000_A5A5, 1'b1};
        vecs[16] = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_0077, 1'b1, 5'd22, 1'b0, 32'h0,
                     1'b1, 5'd22, 32'h0000_0077, 1'b1};

        drive(1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
        reset_n = 1'b0;
        #12;
        chk("reset stall", 32'(stall_WB), 32'd0);
        chk_port("reset", 1'b0, 5'd0, 32'h0);
        chk("reset err_mis", 32'(err_misaligned), 32'd0);
        chk("reset err_to", 32'(err_timeout), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].ld, vecs[i].sz, vecs[i].sgn, vecs[i].al, vecs[i].alu, vecs[i].rw,
                  vecs[i].rd, vecs[i].vld, vecs[i].dat);
            #1;
            chk($sformatf("vec%0d stall", i), 32'(stall_WB), 32'd0);
            @(posedge clk);
            #1;
            chk_port($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_a, vecs[i].e_d);
            chk($sformatf("vec%0d err_mis", i), 32'(err_misaligned), 32'(vecs[i].e_mis));
            chk($sformatf("vec%0d err_to", i), 32'(err_timeout), 32'd0);
        end

        // Waited unsigned halfword: three stall cycles, then data.
        @(negedge clk);
        drive(1'b1, 2'd1, 1'b0, 2'd2, 32'h0, 1'b1, 5'd6, 1'b0, 32'hABCD_8001);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("wait%0d stall", c), 32'(stall_WB), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("wait%0d rf_we", c), 32'(rf_we), 32'd0);
            @(negedge clk);
        end
        d_data_valid = 1'b1;
        #1;
        chk("wait data stall", 32'(stall_WB), 32'd0);
        @(posedge clk);
        #1;
        chk_port("wait data", 1'b1, 5'd6, 32'h0000_8001);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 5'd6, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("wait after rf_we", 32'(rf_we), 32'd0);

        // Timeout with MAX_WAIT=4: four stall cycles, then abort.
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b0, 2'd0, 32'h0, 1'b1, 5'd9, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("to%0d stall", c), 32'(stall_WB), 32'd1);
            chk($sformatf("to%0d err_to", c), 32'(err_timeout), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("to%0d rf_we", c), 32'(rf_we), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("to end stall", 32'(stall_WB), 32'd0);
        @(posedge clk);
        #1;
        chk("to end rf_we", 32'(rf_we), 32'd0);
        chk("to end err_to", 32'(err_timeout), 32'd1);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("to sticky", 32'(err_timeout), 32'd1);

        // Reset in the middle of a wait.
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b0, 2'd0, 32'h0, 1'b1, 5'd17, 1'b0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rstw pre stall", 32'(stall_WB), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstw stall", 32'(stall_WB), 32'd0);
        chk_port("rstw", 1'b0, 5'd0, 32'h0);
        chk("rstw err_mis", 32'(err_misaligned), 32'd0);
        chk("rstw err_to", 32'(err_timeout), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_BEEF, 1'b1, 5'd4, 1'b0, 32'h0);
        #1;
        chk("rstw after stall", 32'(stall_WB), 32'd0);
        @(posedge clk);
        #1;
        chk_port("rstw after", 1'b1, 5'd4, 32'h0000_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the DLX pipeline, directly downstream of the memory-access stage.
- Takes the per-instruction controls latched at the MEM/WB boundary and selects either the ALU result or the returned load data.
- For loads, waits for the data-side memory handshake and extracts/extends sub-word load data (big-endian).
- Drives the register-file write port and the WB→EX forwarding path. Stalls the pipeline while a load is outstanding.

Parameters:
MAX_WAIT, 16, max cycles a load may wait for d_data_valid before abort (≥2)
CNT_W, 5, width of wait counter (must hold MAX_WAIT)

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
d_data_valid  input  1  data memory read data valid this cycle
d_data_read  input  32  data memory read data
d_load_enable_WB  input  1  instruction in WB is a load
load_size_WB  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
load_signed_WB  input  1  1 = sign-extend sub-word load, 0 = zero-extend
addr_lo_WB  input  2  low two bits of the load address
ALU_out_WB  input  32  ALU result for non-load instructions
reg_write_WB  input  1  instruction writes Rd
Rd_WB  input  5  destination register
stall_WB  output  1  hold PC and all upstream pipeline registers this cycle
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  5  register-file write address (registered)
rf_wdata  output  32  register-file write data (registered)
ALU_out_WB_backward  output  32  forwarded value, equals rf_wdata
Rd_WB_backward  output  5  forwarded register, equals rf_waddr when rf_we=1, else 0
err_misaligned  output  1  sticky: misaligned load seen
err_timeout  output  1  sticky: load aborted after MAX_WAIT

Behaviour:
Reset:
- Async on reset_n=0.
- State=IDLE, counter=0.
- rf_we=0, rf_waddr=0, rf_wdata=0.
- Both error flags=0.
- stall_WB=0.

General rules:
- Inputs are stable while stall_WB=1, because upstream holds them.
- A write is "committed" at rising edge E: rf_we/rf_waddr/rf_wdata take effect in the cycle after E. The register file latches them on the next edge.
- Writes to Rd_WB=0 are suppressed: rf_we=0 and forward Rd=0.
- No write/commit edge: rf_we=0; rf_waddr/rf_wdata keep their last values.

Misaligned load:
- Condition: load with size=01 and addr_lo[0]=1, or size=10/11 and addr_lo≠00.
- No write, no stall. err_misaligned set at next edge.

FSM states:
- IDLE
  - Non-load with reg_write_WB=1: commit ALU_out_WB, latency 1. stall_WB=0.
  - Aligned load with d_data_valid=1: commit extracted data at this edge. stall_WB=0.
  - Aligned load with d_data_valid=0: stall_WB=1, go to WAIT, counter←1.
- WAIT
  - stall_WB=1 combinationally until data arrives.
  - d_data_valid=1: stall_WB=0 that cycle, commit extracted data, go to IDLE, counter←0.
  - Else if counter==MAX_WAIT: stall_WB=0, no write, err_timeout←1, go to IDLE.
  - Else counter←counter+1.
  - A load with reg_write_WB=0 still stalls and handshakes, but does not write.

Extraction (big-endian):
- Byte select by addr_lo: 00→[31:24], 01→[23:16], 10→[15:8], 11→[7:0].
- Halfword select: addr_lo[1]=0→[31:16], 1→[15:0].
- Word: unchanged.
- Sub-word values are sign- or zero-extended to 32 bits.

Boundaries:
- d_data_valid while not in a load: ignored.
- Back-to-back loads each handshake independently; no overlap.
- Reset mid-WAIT: abort immediately, no write, flags cleared.
- Error flags clear only on reset.

Test Plan:
- Non-load: ALU_out_WB=0x0000_1234, Rd=5, reg_write=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234; Rd_WB_backward=5; stall_WB never 1.
- Signed byte load: addr_lo=01, d_data_read=0x1280_3456, d_data_valid=1 same cycle → rf_wdata=0xFFFF_FF80, no stall. Same stimulus with unsigned → 0x0000_0080.
- Waited halfword load: d_data_valid low 3 cycles, then high with 0xABCD_8001, addr_lo=10, unsigned → stall_WB=1 for exactly 3 cycles; next cycle rf_wdata=0x0000_8001, rf_we=1 for one cycle.
- Timeout: MAX_WAIT=4, load issued, d_data_valid never asserted → stall_WB high 4 cycles, then low; err_timeout=1; rf_we stays 0.
- Misaligned word load: addr_lo=10 → no stall, rf_we=0, err_misaligned=1 and sticky. Load to Rd=0 with valid data → rf_we=0, Rd_WB_backward=0.
- Reset during WAIT: assert reset_n=0 mid-wait → all outputs 0 immediately; after release, a following non-load commits normally.
